// File: rtl/qsn_shift_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : qsn_shift_scheduler_if
// Description : Bus bundle between two QSN requesters and the shift
//               scheduler: per-requester beat handshakes, halt, the QSN
//               control outputs, the completion stream and status flags.
//               master = requester/QSN side, slave = scheduler side.
// Ports       : halt, req{0,1}_{valid,ready,shift,tag,last},
//               qsn_{in_valid,shift_factor,src_sel},
//               done_{valid,src,tag,err}, err_sticky, inflight_cnt, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface qsn_shift_scheduler_if #(
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
);
  logic               halt;
  logic               req0_valid;
  logic               req0_ready;
  logic [SHIFT_W-1:0] req0_shift;
  logic [TAG_W-1:0]   req0_tag;
  logic               req0_last;
  logic               req1_valid;
  logic               req1_ready;
  logic [SHIFT_W-1:0] req1_shift;
  logic [TAG_W-1:0]   req1_tag;
  logic               req1_last;
  logic               qsn_in_valid;
  logic [SHIFT_W-1:0] qsn_shift_factor;
  logic               qsn_src_sel;
  logic               done_valid;
  logic               done_src;
  logic [TAG_W-1:0]   done_tag;
  logic               done_err;
  logic               err_sticky;
  logic [3:0]         inflight_cnt;
  logic               busy;

  modport master (
    output halt,
    output req0_valid, req0_shift, req0_tag, req0_last,
    output req1_valid, req1_shift, req1_tag, req1_last,
    input  req0_ready, req1_ready,
    input  qsn_in_valid, qsn_shift_factor, qsn_src_sel,
    input  done_valid, done_src, done_tag, done_err,
    input  err_sticky, inflight_cnt, busy
  );

  modport slave (
    input  halt,
    input  req0_valid, req0_shift, req0_tag, req0_last,
    input  req1_valid, req1_shift, req1_tag, req1_last,
    output req0_ready, req1_ready,
    output qsn_in_valid, qsn_shift_factor, qsn_src_sel,
    output done_valid, done_src, done_tag, done_err,
    output err_sticky, inflight_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/qsn_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : qsn_shift_scheduler
// Description : Shares one QSN barrel-shift datapath between the VN write-back
//               requester (0) and the CN read requester (1). Round-robin
//               arbitration at burst granularity, shift-factor range check,
//               registered issue to the QSN, and a completion pipeline that
//               mirrors the QSN latency to report (source, tag, err) per beat.
// Ports       : sys_clk - system clock
//               rst     - synchronous active-high reset
//               bus     - qsn_shift_scheduler_if.slave (requests, QSN control,
//                         completions, status)
// Revision    : 1.0 - initial release
// ============================================================================
module qsn_shift_scheduler #(
  parameter int PERMUTATION_LENGTH = 17,
  parameter int SHIFT_W            = 5,
  parameter int TAG_W              = 4,
  parameter int QSN_LATENCY        = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  qsn_shift_scheduler_if.slave  bus
);

  localparam logic [SHIFT_W:0] PERM_LEN = (SHIFT_W+1)'(PERMUTATION_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  state_t             state;
  state_t             state_nxt;
  logic               rr_ptr;
  logic               rr_nxt;
  logic               ready0;
  logic               ready1;
  logic               acc0;
  logic               acc1;
  logic               acc;
  logic [SHIFT_W-1:0] sel_shift;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_in_range;

  logic               issue_valid;
  logic [SHIFT_W-1:0] issue_shift;
  logic               issue_src;
  logic [TAG_W-1:0]   issue_tag;
  logic               issue_err;
  logic               sticky;
  logic [3:0]         inflight;
  entry_t             issue_entry;
  entry_t             pipe [QSN_LATENCY];

  // ---------------------------------------------------------------- arbiter
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Grant is combinational in IDLE so a new burst can start on the cycle
  // right after the previous burst's last beat without a bubble.
  always_comb begin
    ready0    = 1'b0;
    ready1    = 1'b0;
    state_nxt = state;
    rr_nxt    = rr_ptr;
    case (state)
      S_IDLE: begin
        if (!bus.halt) begin
          if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
            ready0 = 1'b1;
          end else if (bus.req1_valid) begin
            ready1 = 1'b1;
          end
        end
      end
      S_LOCK0: ready0 = !bus.halt;
      S_LOCK1: ready1 = !bus.halt;
      default: state_nxt = S_IDLE;
    endcase

    if (ready0 && bus.req0_valid) begin
      if (bus.req0_last) begin
        state_nxt = S_IDLE;
        rr_nxt    = 1'b1;
      end else begin
        state_nxt = S_LOCK0;
      end
    end else if (ready1 && bus.req1_valid) begin
      if (bus.req1_last) begin
        state_nxt = S_IDLE;
        rr_nxt    = 1'b0;
      end else begin
        state_nxt = S_LOCK1;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  assign acc0         = ready0 & bus.req0_valid;
  assign acc1         = ready1 & bus.req1_valid;
  assign acc          = acc0 | acc1;
  assign sel_shift    = acc1 ? bus.req1_shift : bus.req0_shift;
  assign sel_tag      = acc1 ? bus.req1_tag   : bus.req0_tag;
  assign sel_in_range = ({1'b0, sel_shift} < PERM_LEN);

  // ------------------------------------------------------------------ issue
  // Shift/source/tag hold their last values when nothing is accepted so the
  // QSN controller sees a stable shift factor between beats.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_shift <= '0;
      issue_src   <= 1'b0;
      issue_tag   <= '0;
      issue_err   <= 1'b0;
      sticky      <= 1'b0;
    end else begin
      issue_valid <= acc;
      if (acc) begin
        issue_shift <= sel_in_range ? sel_shift : '0;
        issue_src   <= acc1;
        issue_tag   <= sel_tag;
        issue_err   <= !sel_in_range;
        if (!sel_in_range) begin
          sticky <= 1'b1;
        end
      end
    end
  end

  assign bus.qsn_in_valid     = issue_valid;
  assign bus.qsn_shift_factor = issue_shift;
  assign bus.qsn_src_sel      = issue_src;
  assign bus.err_sticky       = sticky;

  // ------------------------------------------------------ completion pipe
  // Mirrors the QSN register stages so the beat's bookkeeping leaves the
  // tail exactly when its data leaves the QSN.
  assign issue_entry = '{valid: issue_valid, src: issue_src,
                         tag: issue_tag, err: issue_err};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < QSN_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= issue_entry;
      for (int i = 1; i < QSN_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.done_valid = pipe[QSN_LATENCY-1].valid;
  assign bus.done_src   = pipe[QSN_LATENCY-1].src;
  assign bus.done_tag   = pipe[QSN_LATENCY-1].tag;
  assign bus.done_err   = pipe[QSN_LATENCY-1].err;

  // ------------------------------------------------------- in-flight count
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue_valid, pipe[QSN_LATENCY-1].valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign bus.inflight_cnt = inflight;
  assign bus.busy         = (state != S_IDLE) || (inflight != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_qsn_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsn_shift_scheduler
// Description : Self-checking bench for qsn_shift_scheduler. A transaction
//               level reference (burst owner, round-robin pointer and a queue
//               of issued beats with their issue cycle) predicts readies,
//               QSN issue, completions and in-flight count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsn_shift_scheduler;

  localparam int LAT  = 2;
  localparam int PLEN = 17;

  logic sys_clk = 1'b0;
  logic rst;

  always #5 sys_clk = ~sys_clk;

  qsn_shift_scheduler_if #(.SHIFT_W(5), .TAG_W(4)) bus ();

  qsn_shift_scheduler #(
    .PERMUTATION_LENGTH(PLEN),
    .SHIFT_W           (5),
    .TAG_W             (4),
    .QSN_LATENCY       (LAT)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct {
    int         ic;
    bit         src;
    logic [3:0] tag;
    bit         err;
  } beat_t;

  beat_t      q[$];
  int         cyc;
  int         m_owner;   // -1: no burst open, else requester holding the lock
  bit         m_rr;
  logic [4:0] m_shift;
  bit         m_src;
  bit         m_sticky;

  task automatic model_reset();
    q.delete();
    m_owner  = -1;
    m_rr     = 1'b0;
    m_shift  = '0;
    m_src    = 1'b0;
    m_sticky = 1'b0;
  endtask

  task automatic step(input bit v0, input logic [4:0] s0, input logic [3:0] t0, input bit l0,
                      input bit v1, input logic [4:0] s1, input logic [3:0] t1, input bit l1,
                      input bit h, input bit r);
    bit         e0, e1, a0, a1, k, iv, dv, ds, de;
    logic [4:0] sh;
    logic [3:0] dt;
    int         cnt;
    bus.req0_valid = v0; bus.req0_shift = s0; bus.req0_tag = t0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_shift = s1; bus.req1_tag = t1; bus.req1_last = l1;
    bus.halt = h;
    rst = r;
    #2;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!h) begin
      if (m_owner == 0)      e0 = 1'b1;
      else if (m_owner == 1) e1 = 1'b1;
      else if (v0 && v1)     begin if (m_rr) e1 = 1'b1; else e0 = 1'b1; end
      else if (v0)           e0 = 1'b1;
      else if (v1)           e1 = 1'b1;
    end
    if (!r) begin
      chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    end
    a0 = v0 && e0;
    a1 = v1 && e1;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (r) begin
      model_reset();
    end else if (a0 || a1) begin
      k  = a1;
      sh = k ? s1 : s0;
      q.push_back('{ic: cyc, src: k, tag: (k ? t1 : t0), err: (int'(sh) >= PLEN)});
      m_shift = (int'(sh) >= PLEN) ? 5'd0 : sh;
      m_src   = k;
      if (int'(sh) >= PLEN) m_sticky = 1'b1;
      if (k ? l1 : l0) begin
        m_owner = -1;
        m_rr    = ~k;
      end else begin
        m_owner = int'(k);
      end
    end
    iv = 0; dv = 0; ds = 0; dt = '0; de = 0; cnt = 0;
    foreach (q[j]) begin
      if (q[j].ic == cyc) iv = 1'b1;
      if (q[j].ic + LAT == cyc) begin
        dv = 1'b1; ds = q[j].src; dt = q[j].tag; de = q[j].err;
      end
      if (q[j].ic < cyc && cyc <= q[j].ic + LAT) cnt++;
    end
    while (q.size() > 0 && q[0].ic + LAT < cyc) void'(q.pop_front());
    chk("qsn_in_valid", 32'(bus.qsn_in_valid), 32'(iv));
    chk("qsn_shift_factor", 32'(bus.qsn_shift_factor), 32'(m_shift));
    chk("qsn_src_sel", 32'(bus.qsn_src_sel), 32'(m_src));
    chk("done_valid", 32'(bus.done_valid), 32'(dv));
    if (dv) begin
      chk("done_src", 32'(bus.done_src), 32'(ds));
      chk("done_tag", 32'(bus.done_tag), 32'(dt));
      chk("done_err", 32'(bus.done_err), 32'(de));
    end
    chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
    chk("inflight_cnt", 32'(bus.inflight_cnt), 32'(cnt));
    chk("busy", 32'(bus.busy), 32'((m_owner >= 0) || (cnt > 0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_qsn_in_valid"}, 32'(bus.qsn_in_valid), 0);
    chk({tag, "_qsn_shift"},    32'(bus.qsn_shift_factor), 0);
    chk({tag, "_qsn_src"},      32'(bus.qsn_src_sel), 0);
    chk({tag, "_done_valid"},   32'(bus.done_valid), 0);
    chk({tag, "_done_src"},     32'(bus.done_src), 0);
    chk({tag, "_done_tag"},     32'(bus.done_tag), 0);
    chk({tag, "_done_err"},     32'(bus.done_err), 0);
    chk({tag, "_err_sticky"},   32'(bus.err_sticky), 0);
    chk({tag, "_inflight"},     32'(bus.inflight_cnt), 0);
    chk({tag, "_busy"},         32'(bus.busy), 0);
  endtask

  // ------------------------------------------------------- sweep vectors
  typedef struct {
    bit         src;
    logic [4:0] shift;
    logic [3:0] tag;
    logic [4:0] exp_shift;
    bit         exp_err;
  } vec_t;

  vec_t vecs [32];

  initial begin
    cyc = 0;
    model_reset();

    for (int i = 0; i < 32; i++) begin
      vecs[i].src       = i[0];
      vecs[i].shift     = 5'(i);
      vecs[i].tag       = 4'(i * 7);
      vecs[i].exp_shift = (i < PLEN) ? 5'(i) : 5'd0;
      vecs[i].exp_err   = (i >= PLEN);
    end

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_all_zero("reset");

    // Single beat from requester 0
    step(1, 5, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("single_issue_valid", 32'(bus.qsn_in_valid), 1);
    chk("single_issue_shift", 32'(bus.qsn_shift_factor), 5);
    chk("single_issue_src", 32'(bus.qsn_src_sel), 0);
    idle(2);
    chk("single_done_valid", 32'(bus.done_valid), 1);
    chk("single_done_tag", 32'(bus.done_tag), 3);
    chk("single_done_err", 32'(bus.done_err), 0);
    idle(1);

    // Contention: pointer is 1 now; a lone r1 beat returns it to 0
    step(0, 0, 0, 0, 1, 2, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 5'(i + 1), 4'(i), (i == 3), 1, 7, 9, 1, 0, 0);
      chk("contention_src", 32'(bus.qsn_src_sel), 0);
    end
    step(0, 0, 0, 0, 1, 7, 9, 1, 0, 0);
    chk("contention_r1_issue", 32'(bus.qsn_in_valid), 1);
    chk("contention_r1_src", 32'(bus.qsn_src_sel), 1);
    idle(3);

    // Range check
    step(0, 0, 0, 0, 1, 17, 1, 0, 0, 0);
    chk("range17_shift", 32'(bus.qsn_shift_factor), 0);
    chk("range17_sticky", 32'(bus.err_sticky), 1);
    step(0, 0, 0, 0, 1, 16, 2, 1, 0, 0);
    chk("range16_shift", 32'(bus.qsn_shift_factor), 16);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("range17_done_err", 32'(bus.done_err), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("range16_done_err", 32'(bus.done_err), 0);
    idle(2);

    // Halt mid-burst in LOCK0, r1 also knocking
    step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4, 2, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 6, 3, 0, 1, 1, 1, 1, 1, 0);
    chk("halt_busy", 32'(bus.busy), 1);
    step(0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
    chk("halt_drained", 32'(bus.inflight_cnt), 0);
    step(1, 6, 3, 1, 1, 1, 1, 1, 0, 0);
    chk("halt_resume_src", 32'(bus.qsn_src_sel), 0);
    idle(4);

    // Reset with a locked r1 burst and beats in flight
    step(0, 0, 0, 0, 1, 8, 4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10, 6, 0, 0, 0);
    chk("pre_reset_inflight", 32'(bus.inflight_cnt), 2);
    step(0, 0, 0, 0, 1, 11, 7, 0, 0, 1);
    chk_all_zero("midreset");
    idle(4);

    // Sweep every shift value with alternating single-beat bursts
    for (int i = 0; i < 32; i++) begin
      if (vecs[i].src)
        step(0, 0, 0, 0, 1, vecs[i].shift, vecs[i].tag, 1, 0, 0);
      else
        step(1, vecs[i].shift, vecs[i].tag, 1, 0, 0, 0, 0, 0, 0);
      chk("sweep_shift", 32'(bus.qsn_shift_factor), 32'(vecs[i].exp_shift));
      idle(2);
      chk("sweep_done_src", 32'(bus.done_src), 32'(vecs[i].src));
      chk("sweep_done_tag", 32'(bus.done_tag), 32'(vecs[i].tag));
      chk("sweep_done_err", 32'(bus.done_err), 32'(vecs[i].exp_err));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 4'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 4'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 199) == 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
